// File: rtl/uart_cmd_decoder.sv
// Hamming(7,4) command-byte decoder driving a registered output enable, with saturating error/overrun counters.
// Define UART_CMD_ACK_EN to build the ACK/NAK reply handshake towards uart_tx and its timeout.
module uart_cmd_decoder #(
    parameter int unsigned TX_TIMEOUT = 48000,
    parameter logic [7:0]  ACK_BYTE   = 8'h3C,
    parameter logic [7:0]  NAK_BYTE   = 8'hC3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic       start_tx,
    output logic [7:0] data_to_tx,
    output logic       out_enable,
    output logic       cmd_strobe,
    output logic [3:0] cmd_code,
    output logic       corrected,
    output logic [7:0] err_count,
    output logic [7:0] ovr_count
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXEC      = 3'd2;
`ifdef UART_CMD_ACK_EN
    localparam logic [2:0] S_ACK_START = 3'd3;
    localparam logic [2:0] S_ACK_WAIT  = 3'd4;
    localparam int unsigned TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
`endif

    localparam logic [3:0] CMD_ON     = 4'h6;
    localparam logic [3:0] CMD_OFF    = 4'hD;
    localparam logic [3:0] CMD_TOGGLE = 4'h9;
    localparam logic [3:0] CMD_PING   = 4'h0;

    logic [2:0] state, state_d;
    logic       rx_q;
    logic       rx_rise;
    logic [7:0] byte_q;
    logic       perr_q;
    logic [2:0] synd_q;
    logic [3:0] nib_q;
    logic [6:0] cw;
    logic [6:0] cw_fix;
    logic [2:0] synd;
    logic [3:0] nib_fix;
    logic       nib_valid;
    logic       reject;
    logic       tmo_fail;
    logic       err_inc;

    assign rx_rise = rx_done & ~rx_q;

    // Syndrome of the latched codeword and the single-bit-corrected data nibble.
    always_comb begin
        cw      = byte_q[6:0];
        synd    = 3'd0;
        synd[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        synd[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        synd[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        cw_fix  = cw ^ 7'((8'd1 << synd) >> 1);
        nib_fix = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
    end

    always_comb begin
        nib_valid = 1'b0;
        case (nib_q)
            CMD_ON, CMD_OFF, CMD_TOGGLE, CMD_PING: nib_valid = 1'b1;
            default:                               nib_valid = 1'b0;
        endcase
        reject = perr_q | ~byte_q[7] | ~nib_valid;
    end

`ifdef UART_CMD_ACK_EN
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit  = (tmo_cnt == TW'(TX_TIMEOUT - 1));
    assign tmo_fail = (state == S_ACK_START) & ~tx_busy & tmo_hit;

    // Reply request: start_tx held until tx_busy is seen or the timeout expires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_tx   <= 1'b0;
            data_to_tx <= 8'd0;
            tmo_cnt    <= '0;
        end else begin
            start_tx <= 1'b0;
            case (state)
                S_EXEC: begin
                    data_to_tx <= reject ? NAK_BYTE : ACK_BYTE;
                    tmo_cnt    <= '0;
                end
                S_ACK_START: begin
                    if (!tx_busy && !tmo_hit) begin
                        start_tx <= 1'b1;
                        tmo_cnt  <= tmo_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_tx;

    assign tmo_fail   = 1'b0;
    assign start_tx   = 1'b0;
    assign data_to_tx = 8'd0;
    assign unused_tx  = ^{tx_busy, ACK_BYTE, NAK_BYTE, TX_TIMEOUT};
`endif

    assign err_inc = ((state == S_EXEC) & reject) | tmo_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:      if (rx_rise) state_d = S_DECODE;
            S_DECODE:    state_d = S_EXEC;
`ifdef UART_CMD_ACK_EN
            S_EXEC:      state_d = S_ACK_START;
            S_ACK_START: begin
                if (tx_busy)      state_d = S_ACK_WAIT;
                else if (tmo_hit) state_d = S_IDLE;
            end
            S_ACK_WAIT:  if (!tx_busy) state_d = S_IDLE;
`else
            S_EXEC:      state_d = S_IDLE;
`endif
            default:     state_d = S_IDLE;
        endcase
    end

    // Byte capture, decode pipeline, command execution and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q       <= 1'b0;
            byte_q     <= 8'd0;
            perr_q     <= 1'b0;
            synd_q     <= 3'd0;
            nib_q      <= 4'd0;
            out_enable <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd_code   <= 4'd0;
            corrected  <= 1'b0;
            err_count  <= 8'd0;
            ovr_count  <= 8'd0;
        end else begin
            rx_q       <= rx_done;
            cmd_strobe <= 1'b0;
            if (state == S_IDLE && rx_rise) begin
                byte_q <= data_received;
                perr_q <= parity_error;
            end
            if (state == S_DECODE) begin
                synd_q <= synd;
                nib_q  <= nib_fix;
            end
            if (state == S_EXEC && !reject) begin
                cmd_strobe <= 1'b1;
                cmd_code   <= nib_q;
                corrected  <= (synd_q != 3'd0);
                case (nib_q)
                    CMD_ON:     out_enable <= 1'b1;
                    CMD_OFF:    out_enable <= 1'b0;
                    CMD_TOGGLE: out_enable <= ~out_enable;
                    default:    ;
                endcase
            end
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (rx_rise && state != S_IDLE && ovr_count != 8'hFF)
                ovr_count <= ovr_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command bytes, scoreboarded strobes/replies, counter and reset checks.
// Reply checks are active when UART_CMD_ACK_EN is defined.
module tb_uart_cmd_decoder;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_received = 8'd0;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic       start_tx;
    logic [7:0] data_to_tx;
    logic       out_enable;
    logic       cmd_strobe;
    logic [3:0] cmd_code;
    logic       corrected;
    logic [7:0] err_count;
    logic [7:0] ovr_count;

    uart_cmd_decoder #(
        .TX_TIMEOUT (TMO),
        .ACK_BYTE   (8'h3C),
        .NAK_BYTE   (8'hC3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .tx_busy       (tx_busy),
        .start_tx      (start_tx),
        .data_to_tx    (data_to_tx),
        .out_enable    (out_enable),
        .cmd_strobe    (cmd_strobe),
        .cmd_code      (cmd_code),
        .corrected     (corrected),
        .err_count     (err_count),
        .ovr_count     (ovr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       oe;
        logic       corr;
    } strobe_t;

    strobe_t    exp_strobe[$];
    logic [7:0] exp_reply[$];
    strobe_t    mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       m_oe = 1'b0;
    logic       m_corr = 1'b0;
    logic [3:0] m_code = 4'd0;
    int         m_err = 0;
    int         m_ovr = 0;
    logic       st_prev = 1'b0;
    int         req_cnt = 0;
    int         busy_cnt = 0;
    int         busy_len = 4;
    bit         tx_dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a command or raises start_tx.
    always @(negedge clk) begin
        if (cmd_strobe) begin
            if (exp_strobe.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_e = exp_strobe.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("strobe_cmd_code", 32'(cmd_code), 32'(mon_e.code));
                check("strobe_out_enable", 32'(out_enable), 32'(mon_e.oe));
                check("strobe_corrected", 32'(corrected), 32'(mon_e.corr));
            end
        end
`ifdef UART_CMD_ACK_EN
        if (start_tx && !st_prev) begin
            if (exp_reply.size() == 0) check("unexpected_reply", 32'd1, 32'd0);
            else                       check("reply_byte", 32'(data_to_tx), 32'(exp_reply.pop_front()));
        end
`endif
        st_prev = start_tx;
    end

    // uart_tx model: tx_busy rises two cycles into a request and stays high busy_len cycles.
    always @(negedge clk) begin
        if (reset || tx_dead) begin
            tx_busy  = 1'b0;
            req_cnt  = 0;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (start_tx) begin
            req_cnt++;
            if (req_cnt == 2) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
                req_cnt  = 0;
            end
        end else begin
            req_cnt = 0;
        end
    end

    // Drive one byte; the expected strobe/reply is pushed before the DUT can respond.
    task automatic send(input logic [7:0] b, input logic pe, input logic acc,
                        input logic [3:0] code, input logic corr, input int hold);
        strobe_t e;
        @(negedge clk);
        data_received = b;
        parity_error  = pe;
        rx_done       = 1'b1;
        if (acc) begin
            case (code)
                4'h6:    m_oe = 1'b1;
                4'hD:    m_oe = 1'b0;
                4'h9:    m_oe = ~m_oe;
                default: ;
            endcase
            m_code = code;
            m_corr = corr;
            e.cyc  = cyc + 3;
            e.code = code;
            e.oe   = m_oe;
            e.corr = corr;
            exp_strobe.push_back(e);
        end else if (m_err < 255) begin
            m_err++;
        end
`ifdef UART_CMD_ACK_EN
        exp_reply.push_back(acc ? 8'h3C : 8'hC3);
`endif
        repeat (hold) @(negedge clk);
        rx_done      = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out_enable"}, 32'(out_enable), 32'(m_oe));
        check({tag, "_cmd_code"}, 32'(cmd_code), 32'(m_code));
        check({tag, "_corrected"}, 32'(corrected), 32'(m_corr));
        check({tag, "_err_count"}, 32'(err_count), 32'(m_err));
        check({tag, "_ovr_count"}, 32'(ovr_count), 32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start_tx"}, 32'(start_tx), 32'd0);
        check({tag, "_data_to_tx"}, 32'(data_to_tx), 32'd0);
        check({tag, "_out_enable"}, 32'(out_enable), 32'd0);
        check({tag, "_cmd_strobe"}, 32'(cmd_strobe), 32'd0);
        check({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
        check({tag, "_corrected"}, 32'(corrected), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_ovr_count"}, 32'(ovr_count), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Valid commands, clean and single-bit corrected.
        send(8'hB3, 1'b0, 1'b1, 4'h6, 1'b0, 1); idle(20); check_state("on");
        send(8'hA3, 1'b0, 1'b1, 4'h6, 1'b1, 1); idle(20); check_state("on_fix_cw4");
        send(8'hE6, 1'b0, 1'b1, 4'hD, 1'b0, 1); idle(20); check_state("off");
        send(8'hCC, 1'b0, 1'b1, 4'h9, 1'b0, 1); idle(20); check_state("toggle");
        send(8'hCD, 1'b0, 1'b1, 4'h9, 1'b1, 1); idle(20); check_state("toggle_fix_p1");
        send(8'hC0, 1'b0, 1'b1, 4'h0, 1'b1, 1); idle(20); check_state("ping_fix_cw6");
        send(8'hCC, 1'b0, 1'b1, 4'h9, 1'b0, 1); idle(20); check_state("toggle2");

        // Rejections: marker clear, parity error, invalid nibble.
        send(8'h33, 1'b0, 1'b0, 4'h0, 1'b0, 1); idle(20); check_state("rej_marker");
        send(8'hB3, 1'b1, 1'b0, 4'h0, 1'b0, 1); idle(20); check_state("rej_parity");
        send(8'h87, 1'b0, 1'b0, 4'h0, 1'b0, 1); idle(20); check_state("rej_nibble");

        // Second rx_done rise while busy is dropped as an overrun.
        send(8'hB3, 1'b0, 1'b1, 4'h6, 1'b0, 1);
`ifdef UART_CMD_ACK_EN
        idle(4);
`else
        idle(1);
`endif
        data_received = 8'hE6;
        rx_done       = 1'b1;
        m_ovr++;
        idle(1);
        rx_done = 1'b0;
        idle(20); check_state("overrun");

        // rx_done held high is taken once.
        send(8'hE6, 1'b0, 1'b1, 4'hD, 1'b0, 12); idle(20); check_state("held_rx");

`ifdef UART_CMD_ACK_EN
        // No tx_busy: start_tx stays up for the timeout window, then errors back to IDLE.
        tx_dead = 1'b1;
        send(8'hB3, 1'b0, 1'b1, 4'h6, 1'b0, 1);
        idle(17);
        check("tmo_start_tx_before", 32'(start_tx), 32'd1);
        idle(1);
        m_err++;
        check("tmo_start_tx_after", 32'(start_tx), 32'd0);
        idle(3);
        check_state("timeout");
        tx_dead = 1'b0;
        send(8'hE6, 1'b0, 1'b1, 4'hD, 1'b0, 1); idle(20); check_state("after_timeout");

        // Asynchronous reset while waiting on a long tx_busy.
        busy_len = 40;
        send(8'hCC, 1'b0, 1'b1, 4'h9, 1'b0, 1);
        idle(8);
        check("pre_reset_tx_busy", 32'(tx_busy), 32'd1);
`else
        send(8'hCC, 1'b0, 1'b1, 4'h9, 1'b0, 1);
        idle(8);
`endif
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        m_oe = 1'b0; m_corr = 1'b0; m_code = 4'd0; m_err = 0; m_ovr = 0;
        busy_len = 4;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            send(8'h33, 1'b0, 1'b0, 4'h0, 1'b0, 1);
            idle(12);
            if (i == 254) check("err_count_at_255", 32'(err_count), 32'd255);
        end
        check_state("saturated");

        idle(10);
        check("strobes_outstanding", 32'(exp_strobe.size()), 32'd0);
        check("replies_outstanding", 32'(exp_reply.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
